// File: rtl/mem_port_arbiter_pkg.sv
// Shared types and defaults for the two-port memory arbiter.
package mem_port_arbiter_pkg;

  localparam int ADDR_W_DEF = 16;
  localparam int DATA_W_DEF = 32;

  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    ACCESS = 2'b01,
    RESP   = 2'b10
  } state_e;

  typedef enum logic {
    PORT_CPU = 1'b0,
    PORT_DBG = 1'b1
  } port_e;

endpackage

// File: rtl/mem_port_arbiter_rr_arb2.sv
// Two-requester round-robin decision; on a tie the port not granted last wins.
module rr_arb2
  import mem_port_arbiter_pkg::*;
(
  input  logic [1:0] req,
  input  port_e      last_grant,
  output logic       grant_valid,
  output port_e      grant_id
);

  // req[0] is the CPU, req[1] is the debug port
  always_comb begin
    grant_valid = req[0] | req[1];
    grant_id    = PORT_CPU;
    case (req)
      2'b01:   grant_id = PORT_CPU;
      2'b10:   grant_id = PORT_DBG;
      2'b11:   grant_id = (last_grant == PORT_CPU) ? PORT_DBG : PORT_CPU;
      default: grant_id = PORT_CPU;
    endcase
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Arbitrates CPU and debug/loader ports onto one synchronous memory port.
// Every output comes from a register; one access is in flight at a time.
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic              cpu_ack,
  output logic [DATA_W-1:0] cpu_rdata,
  input  logic              dbg_req,
  input  logic              dbg_we,
  input  logic [ADDR_W-1:0] dbg_addr,
  input  logic [DATA_W-1:0] dbg_wdata,
  output logic              dbg_ack,
  output logic [DATA_W-1:0] dbg_rdata,
  input  logic              dbg_hold,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              busy
);

  state_e            state_q;
  port_e             last_q;
  port_e             lat_port_q;
  logic              lat_we_q;
  logic [ADDR_W-1:0] mem_addr_q;
  logic [DATA_W-1:0] mem_wdata_q;
  logic              mem_en_q;
  logic              mem_we_q;
  logic              cpu_ack_q;
  logic              dbg_ack_q;
  logic [DATA_W-1:0] cpu_rdata_q;
  logic [DATA_W-1:0] dbg_rdata_q;

  logic              grant_valid;
  port_e             grant_id;
  logic              win_we_d;
  logic [ADDR_W-1:0] win_addr_d;
  logic [DATA_W-1:0] win_wdata_d;

  rr_arb2 u_arb (
    .req         ({dbg_req, cpu_req & ~dbg_hold}),
    .last_grant  (last_q),
    .grant_valid (grant_valid),
    .grant_id    (grant_id)
  );

  // Select the request fields of whichever port wins this cycle
  always_comb begin
    if (grant_id == PORT_DBG) begin
      win_we_d    = dbg_we;
      win_addr_d  = dbg_addr;
      win_wdata_d = dbg_wdata;
    end else begin
      win_we_d    = cpu_we;
      win_addr_d  = cpu_addr;
      win_wdata_d = cpu_wdata;
    end
  end

  // FSM with registered outputs; ack and rdata land on the edge that leaves RESP
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      last_q      <= PORT_DBG;
      lat_port_q  <= PORT_CPU;
      lat_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      mem_en_q    <= 1'b0;
      mem_we_q    <= 1'b0;
      cpu_ack_q   <= 1'b0;
      dbg_ack_q   <= 1'b0;
      cpu_rdata_q <= '0;
      dbg_rdata_q <= '0;
    end else begin
      mem_en_q  <= 1'b0;
      mem_we_q  <= 1'b0;
      cpu_ack_q <= 1'b0;
      dbg_ack_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (grant_valid) begin
            lat_port_q  <= grant_id;
            lat_we_q    <= win_we_d;
            mem_addr_q  <= win_addr_d;
            mem_wdata_q <= win_wdata_d;
            mem_en_q    <= 1'b1;
            mem_we_q    <= win_we_d;
            state_q     <= ACCESS;
          end else begin
            state_q <= IDLE;
          end
        end
        ACCESS: state_q <= RESP;
        RESP: begin
          if (lat_port_q == PORT_CPU) begin
            cpu_ack_q <= 1'b1;
            if (!lat_we_q) cpu_rdata_q <= mem_rdata;
          end else begin
            dbg_ack_q <= 1'b1;
            if (!lat_we_q) dbg_rdata_q <= mem_rdata;
          end
          last_q  <= lat_port_q;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign cpu_ack   = cpu_ack_q;
  assign dbg_ack   = dbg_ack_q;
  assign cpu_rdata = cpu_rdata_q;
  assign dbg_rdata = dbg_rdata_q;
  assign mem_en    = mem_en_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign busy      = (state_q != IDLE);

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed self-checking bench for mem_port_arbiter with a one-cycle-latency memory model.
module tb_mem_port_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        cpu_req, cpu_we, dbg_req, dbg_we, dbg_hold;
  logic [15:0] cpu_addr, dbg_addr, mem_addr;
  logic [31:0] cpu_wdata, dbg_wdata, mem_wdata, mem_rdata, cpu_rdata, dbg_rdata;
  logic        cpu_ack, dbg_ack, mem_en, mem_we, busy;

  logic [31:0] mem [0:255];
  int n_pass  = 0;
  int n_total = 0;

  always #5 clk = ~clk;

  mem_port_arbiter dut (
    .clk(clk), .reset(reset),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_ack(cpu_ack), .cpu_rdata(cpu_rdata),
    .dbg_req(dbg_req), .dbg_we(dbg_we), .dbg_addr(dbg_addr), .dbg_wdata(dbg_wdata),
    .dbg_ack(dbg_ack), .dbg_rdata(dbg_rdata), .dbg_hold(dbg_hold),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .busy(busy)
  );

  // Synchronous memory: read data appears the cycle after mem_en
  always @(posedge clk) begin
    if (mem_en) begin
      if (mem_we) mem[mem_addr[7:0]] <= mem_wdata;
      mem_rdata <= mem[mem_addr[7:0]];
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 32'hC0DE_0000 | i;
    mem[4] = 32'hDEAD_BEEF;
    mem_rdata = 32'h0;
    cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = 16'h0; cpu_wdata = 32'h0;
    dbg_req = 1'b0; dbg_we = 1'b0; dbg_addr = 16'h0; dbg_wdata = 32'h0;
    dbg_hold = 1'b0;

    // Reset state
    do_reset();
    chk("rst_outputs", {cpu_ack, dbg_ack, mem_en, mem_we, busy}, 64'h0);
    chk("rst_addr", mem_addr, 64'h0);
    chk("rst_wdata", mem_wdata, 64'h0);
    chk("rst_rdata", {cpu_rdata, dbg_rdata}, 64'h0);

    // Single CPU read of address 4
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 16'h0004;
    tick();
    chk("rd_access", {mem_en, mem_we, busy, cpu_ack}, 64'b1010);
    chk("rd_addr", mem_addr, 64'h4);
    tick();
    chk("rd_resp", {mem_en, busy, cpu_ack}, 64'b010);
    tick();
    chk("rd_ack", {cpu_ack, dbg_ack, busy}, 64'b100);
    chk("rd_data", cpu_rdata, 64'hDEAD_BEEF);
    cpu_req = 1'b0;
    tick();
    chk("rd_after", {cpu_ack, mem_en, busy}, 64'b000);

    // Simultaneous requests from reset: CPU write then debug read-back
    do_reset();
    cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 16'h0010; cpu_wdata = 32'h11;
    dbg_req = 1'b1; dbg_we = 1'b0; dbg_addr = 16'h0010;
    tick();
    chk("tie_cpu_first", {mem_en, mem_we}, 64'b11);
    chk("tie_waddr", {mem_addr, mem_wdata}, {16'h0010, 32'h11});
    tick();
    tick();
    chk("tie_cpu_ack", {cpu_ack, dbg_ack}, 64'b10);
    cpu_req = 1'b0;
    tick();
    chk("tie_dbg_access", {mem_en, mem_we, mem_addr}, {2'b10, 16'h0010});
    tick();
    tick();
    chk("tie_dbg_ack", {cpu_ack, dbg_ack}, 64'b01);
    chk("tie_dbg_rdata", dbg_rdata, 64'h11);
    chk("wr_keeps_rdata", cpu_rdata, 64'h0);
    dbg_req = 1'b0;

    // Continuous contention for 12 cycles: acks alternate CPU, dbg, CPU, dbg
    do_reset();
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 16'h0020;
    dbg_req = 1'b1; dbg_we = 1'b0; dbg_addr = 16'h0021;
    for (int i = 1; i <= 12; i++) begin
      tick();
      chk($sformatf("rr_cpu_ack_c%0d", i), cpu_ack, ((i == 3) || (i == 9)) ? 64'h1 : 64'h0);
      chk($sformatf("rr_dbg_ack_c%0d", i), dbg_ack, ((i == 6) || (i == 12)) ? 64'h1 : 64'h0);
    end
    cpu_req = 1'b0; dbg_req = 1'b0;
    chk("rr_cpu_rdata", cpu_rdata, 64'hC0DE_0020);
    chk("rr_dbg_rdata", dbg_rdata, 64'hC0DE_0021);

    // dbg_hold blocks the CPU port
    tick();
    dbg_hold = 1'b1;
    cpu_req = 1'b1; cpu_addr = 16'h0030;
    for (int i = 1; i <= 10; i++) begin
      tick();
      chk($sformatf("hold_c%0d", i), {mem_en, cpu_ack, busy}, 64'b000);
    end
    dbg_hold = 1'b0;
    tick();
    chk("unhold_en", mem_en, 64'h1);
    tick();
    tick();
    chk("unhold_ack", cpu_ack, 64'h1);
    chk("unhold_rdata", cpu_rdata, 64'hC0DE_0030);
    cpu_req = 1'b0;

    // Reset during the ACCESS cycle of a CPU read
    tick();
    cpu_req = 1'b1; cpu_addr = 16'h0004;
    tick();
    chk("mid_access", {mem_en, busy}, 64'b11);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    cpu_req = 1'b0;
    chk("mid_rst_flags", {cpu_ack, dbg_ack, mem_en, mem_we, busy}, 64'h0);
    chk("mid_rst_bus", {mem_addr, mem_wdata}, 64'h0);
    chk("mid_rst_rdata", cpu_rdata, 64'h0);
    tick();
    chk("mid_rst_noack", {cpu_ack, mem_en}, 64'b00);
    tick();
    chk("mid_rst_noack2", {cpu_ack, busy}, 64'b00);

    // Request dropped and fields changed after grant; hold rises mid-access
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 16'h0022;
    tick();
    cpu_req = 1'b0; cpu_addr = 16'h0099; dbg_hold = 1'b1;
    chk("drop_access", {mem_en, mem_addr}, {1'b1, 16'h0022});
    tick();
    chk("drop_resp", {mem_en, busy, cpu_ack}, 64'b010);
    tick();
    chk("drop_ack", cpu_ack, 64'h1);
    chk("drop_rdata", cpu_rdata, 64'hC0DE_0022);
    dbg_hold = 1'b0;
    for (int i = 1; i <= 3; i++) begin
      tick();
      chk($sformatf("drop_nogrant_c%0d", i), {cpu_ack, mem_en, busy}, 64'b000);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
